// File: rtl/issue_queue_param.sv
// ---------------------------------------------------------------------------
// issue_queue_param
//   Out-of-order issue queue between rename and execute. Holds up to DEPTH
//   renamed instructions, each with NUM_SRC source operands. Source values are
//   captured from NUM_WAKE result broadcast channels. A broadcast on the same
//   edge as an enqueue is bypassed straight into the new entry. One ready
//   instruction issues per cycle, oldest first relative to the ROB head.
//   Entries marked serial wait until their sequence number reaches the ROB
//   head.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   FLUSH               synchronous clear of every entry (wins over enq/issue)
//   STALL               execute busy: nothing leaves the queue
//   enq_*               rename-side enqueue: payload, age, serial flag, and
//                       per-source tag/ready/value
//   enq_ready           a free slot exists (combinational from registered
//                       valid bits)
//   wake_*              result broadcast: strobe, tag and value per channel
//   rob_head            sequence number currently at the ROB head
//   iss_*               registered issue strobe, payload, operands and age
//   occupancy           number of valid entries
// ---------------------------------------------------------------------------
module issue_queue_param #(
  parameter int DEPTH     = 16,
  parameter int NUM_SRC   = 3,
  parameter int NUM_WAKE  = 2,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 138,
  parameter int AGE_W     = 32
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FLUSH,
  input  logic                        STALL,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [PAYLOAD_W-1:0]        enq_payload,
  input  logic [AGE_W-1:0]            enq_age,
  input  logic                        enq_serial,
  input  logic [NUM_SRC*TAG_W-1:0]    enq_src_tag,
  input  logic [NUM_SRC-1:0]          enq_src_rdy,
  input  logic [NUM_SRC*DATA_W-1:0]   enq_src_val,
  input  logic [NUM_WAKE-1:0]         wake_valid,
  input  logic [NUM_WAKE*TAG_W-1:0]   wake_tag,
  input  logic [NUM_WAKE*DATA_W-1:0]  wake_val,
  input  logic [AGE_W-1:0]            rob_head,
  output logic                        iss_valid,
  output logic [PAYLOAD_W-1:0]        iss_payload,
  output logic [NUM_SRC*DATA_W-1:0]   iss_src_val,
  output logic [AGE_W-1:0]            iss_age,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  // Entry storage
  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     serial_r;
  logic [AGE_W-1:0]     age_r      [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r  [DEPTH];
  logic [NUM_SRC-1:0]   src_rdy_r  [DEPTH];
  logic [TAG_W-1:0]     src_tag_r  [DEPTH][NUM_SRC];
  logic [DATA_W-1:0]    src_val_r  [DEPTH][NUM_SRC];

  // Output registers
  logic                      iss_valid_r;
  logic [PAYLOAD_W-1:0]      iss_payload_r;
  logic [NUM_SRC*DATA_W-1:0] iss_src_val_r;
  logic [AGE_W-1:0]          iss_age_r;
  logic [OCC_W-1:0]          occupancy_r;

  // Combinational control
  logic                 free_found_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 enq_fire_s;
  logic [NUM_SRC-1:0]   enq_rdy_s;
  logic [DATA_W-1:0]    enq_val_s  [NUM_SRC];
  logic [NUM_SRC-1:0]   wk_rdy_s   [DEPTH];
  logic [DATA_W-1:0]    wk_val_s   [DEPTH][NUM_SRC];
  logic [DEPTH-1:0]     elig_s;
  logic [AGE_W-1:0]     dist_s     [DEPTH];
  logic                 sel_found_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [AGE_W-1:0]     best_dist_s;
  logic                 iss_fire_s;

  assign enq_ready  = ~(&valid_r);
  assign enq_fire_s = enq_valid & enq_ready;
  assign iss_fire_s = sel_found_s & ~STALL;

  // Lowest-index free slot, taken from registered valid bits only so a slot
  // freed by issue this edge is not reused until the next cycle.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_r[i] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Enqueue-side readiness and same-cycle bypass. Channels are scanned from
  // highest to lowest index so the lowest matching channel ends up winning.
  // A source already ready at rename keeps its register-file value.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      enq_rdy_s[k] = enq_src_rdy[k] | (enq_src_tag[k*TAG_W +: TAG_W] == {TAG_W{1'b0}});
      enq_val_s[k] = enq_src_val[k*DATA_W +: DATA_W];
      if (!enq_rdy_s[k]) begin
        for (int c = NUM_WAKE - 1; c >= 0; c--) begin
          if (wake_valid[c] && (wake_tag[c*TAG_W +: TAG_W] == enq_src_tag[k*TAG_W +: TAG_W])) begin
            enq_rdy_s[k] = 1'b1;
            enq_val_s[k] = wake_val[c*DATA_W +: DATA_W];
          end else begin
            enq_val_s[k] = enq_val_s[k];
          end
        end
      end else begin
        enq_val_s[k] = enq_val_s[k];
      end
    end
  end

  // Wakeup of resident entries: only unready, non-zero-tag sources of valid
  // entries can capture; lowest matching channel wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk_rdy_s[i] = src_rdy_r[i];
      for (int k = 0; k < NUM_SRC; k++) begin
        wk_val_s[i][k] = src_val_r[i][k];
        if (valid_r[i] && !src_rdy_r[i][k] && (src_tag_r[i][k] != {TAG_W{1'b0}})) begin
          for (int c = NUM_WAKE - 1; c >= 0; c--) begin
            if (wake_valid[c] && (wake_tag[c*TAG_W +: TAG_W] == src_tag_r[i][k])) begin
              wk_rdy_s[i][k] = 1'b1;
              wk_val_s[i][k] = wake_val[c*DATA_W +: DATA_W];
            end else begin
              wk_val_s[i][k] = wk_val_s[i][k];
            end
          end
        end else begin
          wk_val_s[i][k] = wk_val_s[i][k];
        end
      end
    end
  end

  // Eligibility and ROB-relative age; the modular distance keeps ordering
  // correct when sequence numbers wrap.
  always_comb begin
    elig_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = valid_r[i] & (&src_rdy_r[i]) & (~serial_r[i] | (age_r[i] == rob_head));
      dist_s[i] = age_r[i] - rob_head;
    end
  end

  // Oldest-first select among eligible entries
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    best_dist_s = {AGE_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_s[i] && (!sel_found_s || (dist_s[i] < best_dist_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        best_dist_s = dist_s[i];
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Entry state: reset, flush, wakeup capture, issue free and enqueue write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r  <= {DEPTH{1'b0}};
      serial_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i]     <= {AGE_W{1'b0}};
        payload_r[i] <= {PAYLOAD_W{1'b0}};
        src_rdy_r[i] <= {NUM_SRC{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
          src_tag_r[i][k] <= {TAG_W{1'b0}};
          src_val_r[i][k] <= {DATA_W{1'b0}};
        end
      end
    end else if (FLUSH) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        src_rdy_r[i] <= wk_rdy_s[i];
        for (int k = 0; k < NUM_SRC; k++) begin
          src_val_r[i][k] <= wk_val_s[i][k];
        end
      end
      if (iss_fire_s) begin
        valid_r[sel_idx_s] <= 1'b0;
      end
      // Enqueue slot is always a registered-free slot, so it never collides
      // with the issuing entry; written last so it overrides wakeup above.
      if (enq_fire_s) begin
        valid_r[free_idx_s]   <= 1'b1;
        serial_r[free_idx_s]  <= enq_serial;
        age_r[free_idx_s]     <= enq_age;
        payload_r[free_idx_s] <= enq_payload;
        src_rdy_r[free_idx_s] <= enq_rdy_s;
        for (int k = 0; k < NUM_SRC; k++) begin
          src_tag_r[free_idx_s][k] <= enq_src_tag[k*TAG_W +: TAG_W];
          src_val_r[free_idx_s][k] <= enq_val_s[k];
        end
      end
    end
  end

  // Issue output registers; data holds when nothing issues
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iss_valid_r   <= 1'b0;
      iss_payload_r <= {PAYLOAD_W{1'b0}};
      iss_src_val_r <= {(NUM_SRC*DATA_W){1'b0}};
      iss_age_r     <= {AGE_W{1'b0}};
    end else if (FLUSH) begin
      iss_valid_r <= 1'b0;
    end else if (iss_fire_s) begin
      iss_valid_r   <= 1'b1;
      iss_payload_r <= payload_r[sel_idx_s];
      iss_age_r     <= age_r[sel_idx_s];
      for (int k = 0; k < NUM_SRC; k++) begin
        iss_src_val_r[k*DATA_W +: DATA_W] <= src_val_r[sel_idx_s][k];
      end
    end else begin
      iss_valid_r <= 1'b0;
    end
  end

  // Occupancy counter: +1 on enqueue, -1 on issue
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      occupancy_r <= {OCC_W{1'b0}};
    end else if (FLUSH) begin
      occupancy_r <= {OCC_W{1'b0}};
    end else begin
      occupancy_r <= occupancy_r + OCC_W'(enq_fire_s) - OCC_W'(iss_fire_s);
    end
  end

  assign iss_valid   = iss_valid_r;
  assign iss_payload = iss_payload_r;
  assign iss_src_val = iss_src_val_r;
  assign iss_age     = iss_age_r;
  assign occupancy   = occupancy_r;

endmodule

// File: tb/tb_issue_queue_param.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_param
//   Directed bench for issue_queue_param with default parameters. Inputs are
//   driven 1 time unit after each rising edge; outputs are checked at the
//   same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_issue_queue_param;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, STALL;
  logic          enq_valid, enq_ready, enq_serial;
  logic [137:0]  enq_payload;
  logic [31:0]   enq_age;
  logic [17:0]   enq_src_tag;
  logic [2:0]    enq_src_rdy;
  logic [95:0]   enq_src_val;
  logic [1:0]    wake_valid;
  logic [11:0]   wake_tag;
  logic [63:0]   wake_val;
  logic [31:0]   rob_head;
  logic          iss_valid;
  logic [137:0]  iss_payload;
  logic [95:0]   iss_src_val;
  logic [31:0]   iss_age;
  logic [4:0]    occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  issue_queue_param dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
    .enq_age(enq_age), .enq_serial(enq_serial), .enq_src_tag(enq_src_tag),
    .enq_src_rdy(enq_src_rdy), .enq_src_val(enq_src_val),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .wake_val(wake_val),
    .rob_head(rob_head), .iss_valid(iss_valid), .iss_payload(iss_payload),
    .iss_src_val(iss_src_val), .iss_age(iss_age), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [137:0] pay(input logic [31:0] a);
    return {10'h15B, 64'h0123_4567_89AB_CDEF, ~a, a};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_enq(input logic [31:0] age, input logic serial,
                           input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                           input logic [2:0] rdy,
                           input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    enq_valid   = 1'b1;
    enq_age     = age;
    enq_serial  = serial;
    enq_payload = pay(age);
    enq_src_tag = {t2, t1, t0};
    enq_src_rdy = rdy;
    enq_src_val = {v2, v1, v0};
  endtask

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; STALL = 1'b0;
    enq_valid = 1'b0; enq_serial = 1'b0; enq_payload = '0; enq_age = '0;
    enq_src_tag = '0; enq_src_rdy = '0; enq_src_val = '0;
    wake_valid = '0; wake_tag = '0; wake_val = '0; rob_head = '0;
    step(); step();
    RESET = 1'b0;

    // Reset state
    chk("rst_occ", occupancy, 5'd0);
    chk("rst_iss_valid", iss_valid, 1'b0);
    chk("rst_enq_ready", enq_ready, 1'b1);
    chk("rst_iss_age", iss_age, 32'd0);
    chk("rst_iss_payload", iss_payload, 138'd0);
    chk("rst_iss_src", iss_src_val, 96'd0);

    // Wakeup two cycles after enqueue
    drive_enq(32'd7, 1'b0, 6'd0, 6'd12, 6'd0, 3'b101, 32'h100, 32'h111, 32'h300);
    step();
    enq_valid = 1'b0;
    chk("wk_occ1", occupancy, 5'd1);
    chk("wk_not_ready0", iss_valid, 1'b0);
    step();
    chk("wk_not_ready1", iss_valid, 1'b0);
    wake_valid = 2'b10; wake_tag = {6'd12, 6'd0}; wake_val = {32'hDEADBEEF, 32'h0};
    step();
    wake_valid = 2'b00;
    chk("wk_wake_edge", iss_valid, 1'b0);
    step();
    chk("wk_iss_valid", iss_valid, 1'b1);
    chk("wk_iss_age", iss_age, 32'd7);
    chk("wk_src1", iss_src_val[63:32], 32'hDEADBEEF);
    chk("wk_src0", iss_src_val[31:0], 32'h100);
    chk("wk_src2", iss_src_val[95:64], 32'h300);
    chk("wk_payload", iss_payload, pay(32'd7));
    chk("wk_occ0", occupancy, 5'd0);

    // Same-cycle bypass; both channels match, channel 0 wins
    drive_enq(32'd8, 1'b0, 6'd9, 6'd0, 6'd0, 3'b000, 32'hAAAA, 32'h22, 32'h33);
    wake_valid = 2'b11; wake_tag = {6'd9, 6'd9}; wake_val = {32'h66, 32'h55};
    step();
    enq_valid = 1'b0; wake_valid = 2'b00;
    chk("byp_enq_edge", iss_valid, 1'b0);
    step();
    chk("byp_iss_valid", iss_valid, 1'b1);
    chk("byp_iss_age", iss_age, 32'd8);
    chk("byp_src0", iss_src_val[31:0], 32'h55);
    chk("byp_src1", iss_src_val[63:32], 32'h22);
    step();
    chk("byp_idle", iss_valid, 1'b0);
    chk("byp_hold_age", iss_age, 32'd8);

    // Oldest-first across sequence-number wrap
    rob_head = 32'hFFFF_FFFE;
    STALL = 1'b1;
    drive_enq(32'h1, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h1, 32'h2, 32'h3);
    step();
    drive_enq(32'hFFFF_FFFF, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h4, 32'h5, 32'h6);
    step();
    enq_valid = 1'b0;
    chk("wrap_stall_no_issue", iss_valid, 1'b0);
    chk("wrap_occ2", occupancy, 5'd2);
    STALL = 1'b0;
    step();
    chk("wrap_first_valid", iss_valid, 1'b1);
    chk("wrap_first_age", iss_age, 32'hFFFF_FFFF);
    step();
    chk("wrap_second_age", iss_age, 32'h1);
    chk("wrap_second_src0", iss_src_val[31:0], 32'h1);
    chk("wrap_occ0", occupancy, 5'd0);

    // Serial entry waits for the ROB head; younger entry passes it
    rob_head = 32'd18;
    drive_enq(32'd20, 1'b1, 6'd0, 6'd0, 6'd0, 3'b111, 32'h20, 32'h21, 32'h22);
    step();
    drive_enq(32'd25, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h25, 32'h26, 32'h27);
    step();
    enq_valid = 1'b0;
    chk("ser_not_head", iss_valid, 1'b0);
    step();
    chk("ser_young_valid", iss_valid, 1'b1);
    chk("ser_young_age", iss_age, 32'd25);
    step();
    chk("ser_still_wait", iss_valid, 1'b0);
    chk("ser_occ1", occupancy, 5'd1);
    rob_head = 32'd20;
    step();
    chk("ser_head_valid", iss_valid, 1'b1);
    chk("ser_head_age", iss_age, 32'd20);
    chk("ser_occ0", occupancy, 5'd0);

    // Fill under stall, drain, enqueue+issue same edge, flush
    rob_head = 32'd100;
    STALL = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_enq(32'(100 + i), 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'(i), 32'h0, 32'h0);
      step();
    end
    chk("full_occ", occupancy, 5'd16);
    chk("full_enq_ready", enq_ready, 1'b0);
    chk("full_no_issue", iss_valid, 1'b0);
    drive_enq(32'd200, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h0, 32'h0, 32'h0);
    step();
    chk("full_ignore_enq", occupancy, 5'd16);
    enq_valid = 1'b0;
    STALL = 1'b0;
    step();
    chk("drain0_age", iss_age, 32'd100);
    chk("drain0_payload", iss_payload, pay(32'd100));
    chk("drain0_occ", occupancy, 5'd15);
    step();
    chk("drain1_age", iss_age, 32'd101);
    chk("drain1_src0", iss_src_val[31:0], 32'd1);
    chk("drain1_occ", occupancy, 5'd14);
    drive_enq(32'd116, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h0, 32'h0, 32'h0);
    step();
    chk("drain2_age", iss_age, 32'd102);
    chk("drain2_enq_iss_occ", occupancy, 5'd14);
    drive_enq(32'd300, 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h0, 32'h0, 32'h0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0; enq_valid = 1'b0;
    chk("flush_occ", occupancy, 5'd0);
    chk("flush_iss_valid", iss_valid, 1'b0);
    chk("flush_enq_ready", enq_ready, 1'b1);
    chk("flush_hold_age", iss_age, 32'd102);
    step();
    chk("flush_empty_after", iss_valid, 1'b0);
    chk("flush_occ_after", occupancy, 5'd0);

    // Asynchronous reset with 5 entries held
    rob_head = 32'd400;
    STALL = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_enq(32'(400 + i), 1'b0, 6'd0, 6'd0, 6'd0, 3'b111, 32'h0, 32'h0, 32'h0);
      step();
    end
    enq_valid = 1'b0;
    STALL = 1'b0;
    step();
    STALL = 1'b1;
    chk("pre_rst_valid", iss_valid, 1'b1);
    chk("pre_rst_occ", occupancy, 5'd5);
    #1 RESET = 1'b1;
    #1;
    chk("arst_occ", occupancy, 5'd0);
    chk("arst_iss_valid", iss_valid, 1'b0);
    chk("arst_enq_ready", enq_ready, 1'b1);
    chk("arst_iss_age", iss_age, 32'd0);
    #1 RESET = 1'b0;
    STALL = 1'b0;
    step();
    chk("post_rst_empty", iss_valid, 1'b0);
    chk("post_rst_occ", occupancy, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
